// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and sizing helper for the chunk-serial add/sub unit.
package addsub_pkg;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_ADC = 2'b10, OP_SBC = 2'b11} op_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/addsub_chunk.sv
// addsub_chunk: K-bit combinational adder slice with carry in/out.
module addsub_chunk #(
  parameter int K = 8
) (
  input  logic [K-1:0] x,
  input  logic [K-1:0] y,
  input  logic         cin,
  output logic [K-1:0] s,
  output logic         cout
);
  assign {cout, s} = {1'b0, x} + {1'b0, y} + {{K{1'b0}}, cin};
endmodule

// File: rtl/addsub_serial.sv
// addsub_serial: multi-cycle K-bit-per-cycle add/sub/adc/sbc with N/Z/C/V flags.
// Define ADDSUB_SAT_EN to enable signed saturation on overflow via the sat input.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int M = 32,
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic [1:0]   op,
  input  logic         sat,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] resultado,
  output logic         flag_n,
  output logic         flag_z,
  output logic         flag_c,
  output logic         flag_v
);
  localparam int N = M / K;
  localparam int CW = cnt_w(N);
  state_t state;
  op_t o;
  logic [M-1:0] a_r, b_r;
  logic [CW-1:0] cnt;
  logic carry, cflag, z_acc, cout, last, v_w;
  logic [K-1:0] s;
  assign o = op_t'(op);
  assign last = cnt == CW'(N - 1);
  assign v_w = (a_r[M-1] == b_r[M-1]) && (s[K-1] != a_r[M-1]);
  addsub_chunk #(.K(K)) u_chunk (
    .x(a_r[cnt*K +: K]),
    .y(b_r[cnt*K +: K]),
    .cin(carry),
    .s(s),
    .cout(cout)
  );
`ifdef ADDSUB_SAT_EN
  logic sat_r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sat_r <= 1'b0;
    else if (state == IDLE && in_valid) sat_r <= sat;
`else
  logic unused_sat;
  assign unused_sat = sat;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      resultado <= '0;
      {flag_n, flag_z, flag_c, flag_v} <= '0;
      cflag <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      cnt <= '0;
      carry <= 1'b0;
      z_acc <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r <= a;
          b_r <= (o == OP_SUB || o == OP_SBC) ? ~b : b;
          carry <= (o == OP_ADD) ? 1'b0 : (o == OP_SUB) ? 1'b1 : cflag;
          cnt <= '0;
          z_acc <= 1'b0;
          in_ready <= 1'b0;
          state <= RUN;
        end
        RUN: begin
          resultado[cnt*K +: K] <= s;
          carry <= cout;
          z_acc <= z_acc | (|s);
          cnt <= cnt + 1'b1;
          if (last) begin
            flag_n <= s[K-1];
            flag_z <= !(z_acc | (|s));
            flag_c <= cout;
            flag_v <= v_w;
            cflag <= cout;
            out_valid <= 1'b1;
            state <= DONE;
`ifdef ADDSUB_SAT_EN
            // Clamp toward the sign of a; V/C still describe the raw sum.
            if (sat_r && v_w) begin
              resultado <= a_r[M-1] ? {1'b1, {(M-1){1'b0}}} : {1'b0, {(M-1){1'b1}}};
              flag_n <= a_r[M-1];
              flag_z <= 1'b0;
            end
`endif
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: directed-vector bench for addsub_serial at M=8, K=4.
module tb_addsub_serial;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, sat, out_valid, out_ready;
  logic [7:0] a, b, resultado;
  logic [1:0] op;
  logic flag_n, flag_z, flag_c, flag_v;
  logic [3:0] flags;
  int vectors = 0;
  int miscompares = 0;
  assign flags = {flag_n, flag_z, flag_c, flag_v};
  always #5 clk = ~clk;
  addsub_serial #(.M(8), .K(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .sat(sat), .out_valid(out_valid), .out_ready(out_ready),
    .resultado(resultado), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
  );
  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic [1:0] top, input logic tsat);
    int w = 0;
    while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
    vectors++;
    if (!in_ready) begin $display("FAIL accept_timeout in_ready=%b want 1", in_ready); miscompares++; end
    a = ta; b = tb; op = top; sat = tsat; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'hFF; b = 8'hFF; op = 2'b11; sat = 1'b1;
  endtask
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic [1:0] top, input logic tsat, output int lat);
    start_op(ta, tb, top, tsat);
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    sat = 1'b0;
  endtask
  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask
  task automatic test_reset();
    vectors++;
    if ({in_ready, out_valid, resultado, flags} !== {1'b1, 1'b0, 8'h00, 4'h0}) begin
      $display("FAIL reset got rdy=%b vld=%b res=%h flags=%b want 1 0 00 0000", in_ready, out_valid, resultado, flags);
      miscompares++;
    end
  endtask
  task automatic test_add_overflow();
    int lat;
    do_op(8'h7F, 8'h01, 2'b00, 1'b0, lat);
    vectors++;
    if (lat !== 2) begin $display("FAIL add_latency got %0d want 2", lat); miscompares++; end
    vectors++;
    if (resultado !== 8'h80) begin $display("FAIL add_ovf_res got %h want 80", resultado); miscompares++; end
    vectors++;
    if (flags !== 4'b1001) begin $display("FAIL add_ovf_flags got %b want 1001", flags); miscompares++; end
    release_out();
  endtask
  task automatic test_sub();
    int lat;
    do_op(8'h05, 8'h05, 2'b01, 1'b0, lat);
    vectors++;
    if ({resultado, flags} !== {8'h00, 4'b0110}) begin
      $display("FAIL sub_equal got %h/%b want 00/0110", resultado, flags); miscompares++;
    end
    release_out();
    do_op(8'h00, 8'h01, 2'b01, 1'b0, lat);
    vectors++;
    if ({resultado, flags} !== {8'hFF, 4'b1000}) begin
      $display("FAIL sub_borrow got %h/%b want FF/1000", resultado, flags); miscompares++;
    end
    release_out();
  endtask
  task automatic test_carry_chain();
    int lat;
    do_op(8'hFF, 8'h01, 2'b00, 1'b0, lat);
    vectors++;
    if ({resultado, flags} !== {8'h00, 4'b0110}) begin
      $display("FAIL chain_add got %h/%b want 00/0110", resultado, flags); miscompares++;
    end
    release_out();
    do_op(8'h00, 8'h00, 2'b10, 1'b0, lat);
    vectors++;
    if ({resultado, flags} !== {8'h01, 4'b0000}) begin
      $display("FAIL chain_adc got %h/%b want 01/0000", resultado, flags); miscompares++;
    end
    release_out();
    do_op(8'h10, 8'h01, 2'b11, 1'b0, lat);
    vectors++;
    if ({resultado, flags} !== {8'h0E, 4'b0010}) begin
      $display("FAIL chain_sbc got %h/%b want 0E/0010", resultado, flags); miscompares++;
    end
    release_out();
  endtask
  task automatic test_backpressure();
    int lat;
    do_op(8'h12, 8'h34, 2'b00, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 8'h55; b = 8'h66; op = 2'b01;
      @(posedge clk); #1;
      vectors++;
      if ({out_valid, in_ready, resultado, flags} !== {1'b1, 1'b0, 8'h46, 4'b0000}) begin
        $display("FAIL hold_%0d got vld=%b rdy=%b res=%h flags=%b want 1 0 46 0000", i, out_valid, in_ready, resultado, flags);
        miscompares++;
      end
    end
    in_valid = 1'b0;
    release_out();
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      $display("FAIL release got vld=%b rdy=%b want 0 1", out_valid, in_ready); miscompares++;
    end
  endtask
  task automatic test_reset_mid_run();
    int lat;
    do_op(8'hFF, 8'h01, 2'b00, 1'b0, lat);
    release_out();
    start_op(8'h11, 8'h22, 2'b00, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({in_ready, out_valid, resultado, flags} !== {1'b1, 1'b0, 8'h00, 4'h0}) begin
      $display("FAIL mid_reset got rdy=%b vld=%b res=%h flags=%b want 1 0 00 0000", in_ready, out_valid, resultado, flags);
      miscompares++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(8'h01, 8'h01, 2'b10, 1'b0, lat);
    vectors++;
    if ({resultado, flags} !== {8'h02, 4'b0000}) begin
      $display("FAIL post_reset_adc got %h/%b want 02/0000", resultado, flags); miscompares++;
    end
    release_out();
  endtask
`ifdef ADDSUB_SAT_EN
  task automatic test_sat();
    int lat;
    do_op(8'h7F, 8'h01, 2'b00, 1'b1, lat);
    vectors++;
    if ({resultado, flags} !== {8'h7F, 4'b0001}) begin
      $display("FAIL sat_pos got %h/%b want 7F/0001", resultado, flags); miscompares++;
    end
    release_out();
    do_op(8'h80, 8'h01, 2'b01, 1'b1, lat);
    vectors++;
    if ({resultado, flags} !== {8'h80, 4'b1011}) begin
      $display("FAIL sat_neg got %h/%b want 80/1011", resultado, flags); miscompares++;
    end
    release_out();
  endtask
`else
  task automatic test_sat();
    int lat;
    do_op(8'h7F, 8'h01, 2'b00, 1'b1, lat);
    vectors++;
    if ({resultado, flags} !== {8'h80, 4'b1001}) begin
      $display("FAIL sat_ignored got %h/%b want 80/1001", resultado, flags); miscompares++;
    end
    release_out();
  endtask
`endif
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0; sat = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_add_overflow();
    test_sub();
    test_carry_chain();
    test_backpressure();
    test_reset_mid_run();
    test_sat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
